// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: pattern mode codes and
// FSM state encodings.
package led_pkg;

  localparam logic [2:0] MODE_ROTL   = 3'd0;
  localparam logic [2:0] MODE_ROTR   = 3'd1;
  localparam logic [2:0] MODE_BOUNCE = 3'd2;
  localparam logic [2:0] MODE_BAR    = 3'd3;
  localparam logic [2:0] MODE_ALT    = 3'd4;
  localparam logic [2:0] MODE_FLASH  = 3'd5;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/led_prescaler.sv
// Programmable step prescaler.
// Ports:
//   clk, reset : clock, async active-high reset
//   en         : advance the counter this cycle
//   clr        : synchronous clear (pattern restart)
//   div        : terminal count, sampled live; period = div+1
//   tc         : strobe, high when en and cnt == div (step cycle)
// If div drops below cnt the counter keeps incrementing and wraps through
// 2^DIV_W before it meets div again; no clamping.
module led_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tc
);

  logic [DIV_W-1:0] cnt;

  assign tc = en && (cnt == div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= tc ? '0 : cnt + DIV_W'(1);
  end

endmodule

// File: rtl/led_pattern_gen.sv
// WIDTH-bit LED pattern generator with six selectable patterns, a programmable
// step prescaler, pause and restart-on-mode-change.
// Ports:
//   clk, reset : clock, async active-high reset
//   stop       : level, freezes q and the prescaler
//   mode       : pattern select (see led_pkg MODE_*; 6,7 reserved -> all off)
//   div        : step period minus one
//   q          : registered LED outputs
//   tick       : pulse in the cycle q takes a new step value
//   wrap       : pulse when a step returns q to the start pattern
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop,
  input  logic [2:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             wrap
);

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  state_t           state, state_nx;
  logic [2:0]       mode_r;
  logic             dir, dir_nx;
  logic [WIDTH-1:0] pat_nx;
  logic             mode_chg, en, step, valid_mode;

  function automatic logic [WIDTH-1:0] start_pat(input logic [2:0] m);
    logic [WIDTH-1:0] s;
    s = '0;
    case (m)
      MODE_ROTL, MODE_BOUNCE: s[0] = 1'b1;
      MODE_ROTR:              s[WIDTH-1] = 1'b1;
      MODE_ALT:  for (int i = 0; i < WIDTH; i += 2) s[i] = 1'b1;
      default:                s = '0;
    endcase
    return s;
  endfunction

  // LOAD already adopts the live mode, so a change seen there needs no
  // second LOAD pass.
  assign mode_chg   = (mode != mode_r) && (state != S_LOAD);
  assign valid_mode = (mode_r <= MODE_FLASH);
  // stop freezes the prescaler immediately so a step due in that cycle is
  // deferred until the run resumes rather than dropped.
  assign en         = (state == S_RUN) && !stop && !mode_chg;

  led_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (state == S_LOAD),
    .div   (div),
    .tc    (step)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:  state_nx = stop ? S_PAUSE : S_RUN;
      S_RUN:   if (stop)  state_nx = S_PAUSE;
      S_PAUSE: if (!stop) state_nx = S_RUN;
      default: state_nx = S_LOAD;
    endcase
    if (mode_chg) state_nx = S_LOAD;
  end

  always_comb begin
    pat_nx = '0;
    dir_nx = dir;
    case (mode_r)
      MODE_ROTL: pat_nx = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROTR: pat_nx = {q[0], q[WIDTH-1:1]};
      MODE_BOUNCE: begin
        // Direction flips in the step that lands on an end bit.
        if (dir == DIR_UP) begin
          pat_nx = q << 1;
          if (pat_nx[WIDTH-1]) dir_nx = DIR_DN;
        end else begin
          pat_nx = q >> 1;
          if (pat_nx[0]) dir_nx = DIR_UP;
        end
      end
      MODE_BAR:              pat_nx = (&q) ? '0 : {q[WIDTH-2:0], 1'b1};
      MODE_ALT, MODE_FLASH:  pat_nx = ~q;
      default:               pat_nx = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_LOAD;
      mode_r <= '0;
      dir    <= DIR_UP;
      q      <= '0;
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      state <= state_nx;
      tick  <= 1'b0;
      wrap  <= 1'b0;
      if (state == S_LOAD) begin
        q      <= start_pat(mode);
        dir    <= DIR_UP;
        mode_r <= mode;
      end else if (step && valid_mode) begin
        q    <= pat_nx;
        dir  <= dir_nx;
        tick <= 1'b1;
        wrap <= (pat_nx == start_pat(mode_r));
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;

  logic        clk, reset, stop;
  logic [2:0]  mode;
  logic [23:0] div;
  logic [7:0]  q;
  logic        tick, wrap;
  logic [3:0]  q4;
  logic        tick4, wrap4;

  int checks = 0;
  int errors = 0;

  led_pattern_gen #(.WIDTH(8), .DIV_W(24)) dut (
    .clk(clk), .reset(reset), .stop(stop), .mode(mode), .div(div),
    .q(q), .tick(tick), .wrap(wrap)
  );

  led_pattern_gen #(.WIDTH(4), .DIV_W(24)) dut4 (
    .clk(clk), .reset(reset), .stop(stop), .mode(mode), .div(div),
    .q(q4), .tick(tick4), .wrap(wrap4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stop;
    logic [2:0]  mode;
    logic [23:0] div;
    logic [7:0]  q;
    logic        tick;
    logic        wrap;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, input logic [2:0] m, input logic [23:0] d,
                     input logic [7:0] eq, input logic et, input logic ew);
    vec_t v;
    v.stop = s; v.mode = m; v.div = d; v.q = eq; v.tick = et; v.wrap = ew;
    tbl.push_back(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp8(input string name, input logic [7:0] eq, input logic et, input logic ew);
    checks++;
    if ({q, tick, wrap} !== {eq, et, ew}) begin
      errors++;
      $display("FAIL %s: got q=%h tick=%b wrap=%b, want q=%h tick=%b wrap=%b",
               name, q, tick, wrap, eq, et, ew);
    end
  endtask

  task automatic cmp4(input string name, input logic [3:0] eq, input logic et, input logic ew);
    checks++;
    if ({q4, tick4, wrap4} !== {eq, et, ew}) begin
      errors++;
      $display("FAIL %s: got q=%h tick=%b wrap=%b, want q=%h tick=%b wrap=%b",
               name, q4, tick4, wrap4, eq, et, ew);
    end
  endtask

  task automatic step8(input string name, input logic [7:0] eq, input logic et, input logic ew);
    cyc();
    cmp8(name, eq, et, ew);
  endtask

  initial begin
    logic [7:0] prev, nxt;

    // Test 1: ROTL, div=0
    add(0, 3'd0, 0, 8'h01, 0, 0);
    for (int i = 1; i < 8; i++) add(0, 3'd0, 0, 8'(1 << i), 1, 0);
    add(0, 3'd0, 0, 8'h01, 1, 1);
    add(0, 3'd0, 0, 8'h02, 1, 0);
    // Test 2: BOUNCE; first cycle is the mode change (hold), then LOAD
    add(0, 3'd2, 0, 8'h02, 0, 0);
    add(0, 3'd2, 0, 8'h01, 0, 0);
    for (int i = 1; i < 8; i++) add(0, 3'd2, 0, 8'(1 << i), 1, 0);
    for (int i = 6; i >= 1; i--) add(0, 3'd2, 0, 8'(1 << i), 1, 0);
    add(0, 3'd2, 0, 8'h01, 1, 1);
    add(0, 3'd2, 0, 8'h02, 1, 0);

    reset = 1'b1; stop = 1'b0; mode = 3'd0; div = '0;
    #1;
    cmp8("reset_async", 8'h00, 0, 0);
    cyc();
    cmp8("reset_hold", 8'h00, 0, 0);
    cyc();
    reset = 1'b0;

    foreach (tbl[i]) begin
      stop = tbl[i].stop; mode = tbl[i].mode; div = tbl[i].div;
      step8($sformatf("vec%0d", i), tbl[i].q, tbl[i].tick, tbl[i].wrap);
    end

    // Test 3: BAR, div=3 -> step every 4 clocks
    mode = 3'd3; div = 24'd3;
    step8("bar_chg", 8'h02, 0, 0);
    step8("bar_load", 8'h00, 0, 0);
    prev = 8'h00;
    for (int k = 1; k <= 9; k++) begin
      nxt = (k == 9) ? 8'h00 : 8'((9'd1 << k) - 9'd1);
      for (int j = 0; j < 3; j++) step8($sformatf("bar_wait%0d", k), prev, 0, 0);
      step8($sformatf("bar_step%0d", k), nxt, 1, k == 9);
      prev = nxt;
    end

    // Test 4: ROTR div=3, reach 20, pause 20 clks mid-count
    mode = 3'd1;
    step8("rotr_chg", 8'h00, 0, 0);
    step8("rotr_load", 8'h80, 0, 0);
    for (int j = 0; j < 3; j++) step8("rotr_w1", 8'h80, 0, 0);
    step8("rotr_40", 8'h40, 1, 0);
    for (int j = 0; j < 3; j++) step8("rotr_w2", 8'h40, 0, 0);
    step8("rotr_20", 8'h20, 1, 0);
    step8("rotr_c1", 8'h20, 0, 0);
    step8("rotr_c2", 8'h20, 0, 0);
    stop = 1'b1;
    for (int j = 0; j < 20; j++) step8("pause_hold", 8'h20, 0, 0);
    stop = 1'b0;
    step8("pause_exit", 8'h20, 0, 0);
    step8("resume_c3", 8'h20, 0, 0);
    step8("resume_10", 8'h10, 1, 0);
    // stop held exactly in the due step cycle: step deferred, not lost
    for (int j = 0; j < 3; j++) step8("defer_cnt", 8'h10, 0, 0);
    stop = 1'b1;
    step8("defer_stop", 8'h10, 0, 0);
    stop = 1'b0;
    step8("defer_exit", 8'h10, 0, 0);
    step8("defer_08", 8'h08, 1, 0);

    // Test 5: mode change to ALT together with stop
    mode = 3'd4; div = '0; stop = 1'b1;
    step8("alt_chg", 8'h08, 0, 0);
    step8("alt_load", 8'h55, 0, 0);
    for (int j = 0; j < 3; j++) step8("alt_pause", 8'h55, 0, 0);
    stop = 1'b0;
    step8("alt_exit", 8'h55, 0, 0);
    step8("alt_aa", 8'hAA, 1, 0);
    step8("alt_55", 8'h55, 1, 1);
    step8("alt_aa2", 8'hAA, 1, 0);

    // Test 6: reset mid-BOUNCE, then reserved mode stays dark
    mode = 3'd2;
    step8("bnc_chg", 8'hAA, 0, 0);
    step8("bnc_load", 8'h01, 0, 0);
    step8("bnc_02", 8'h02, 1, 0);
    step8("bnc_04", 8'h04, 1, 0);
    reset = 1'b1;
    #1;
    cmp8("mid_reset", 8'h00, 0, 0);
    mode = 3'd6;
    cyc();
    reset = 1'b0;
    step8("rsv_load", 8'h00, 0, 0);
    for (int j = 0; j < 10; j++) step8("rsv_idle", 8'h00, 0, 0);

    // WIDTH=4 rerun of test 1 alongside WIDTH=8
    reset = 1'b1; mode = 3'd0;
    cyc();
    reset = 1'b0;
    cyc();
    cmp4("w4_load", 4'h1, 0, 0);
    cmp8("w8_load", 8'h01, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      cmp4($sformatf("w4_step%0d", i), 4'((5'd1 << i) & 5'hF) | ((i == 4) ? 4'h1 : 4'h0), 1, i == 4);
      cmp8($sformatf("w8_step%0d", i), 8'(1 << i), 1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
